// File: rtl/add_accum_pkg.sv
// Shared definitions for the add/accumulate block: operation encodings
// used by the datapath, the bench and future ALU blocks.
package add_accum_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

endpackage

// File: rtl/add_accum_alu.sv
// Combinational datapath for add_accum: produces the next result, next
// accumulator value and overflow flag for one operation.
module add_accum_alu
    import add_accum_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic [1:0]     op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH:0]   acc_i,
    output logic [WIDTH:0]   next_y_o,
    output logic [WIDTH:0]   next_acc_o,
    output logic             next_ovf_o
);

    logic [WIDTH+1:0] accSum;

    // One guard bit above the accumulator width exposes accumulator overflow.
    assign accSum = {1'b0, acc_i} + {2'b00, a_i};

    always_comb begin
        next_y_o   = '0;
        next_acc_o = acc_i;
        next_ovf_o = 1'b0;
        case (op_i)
            OP_ADD: next_y_o = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB: next_y_o = {1'b0, a_i} - {1'b0, b_i};
            OP_ACC: begin
                if (accSum[WIDTH+1]) begin
                    next_ovf_o = 1'b1;
                    next_acc_o = (SATURATE != 0) ? '1 : accSum[WIDTH:0];
                end else begin
                    next_acc_o = accSum[WIDTH:0];
                end
                next_y_o = next_acc_o;
            end
            OP_CLR: next_acc_o = '0;
            default: next_y_o = '0;
        endcase
    end

endmodule

// File: rtl/add_accum.sv
// Registered add/sub/accumulate unit with valid/ready handshakes on input
// and output; one-cycle latency, full throughput when the consumer is ready.
module add_accum
    import add_accum_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   y_o,
    output logic             ovf_o
);

    logic [WIDTH:0] acc_q, acc_d;
    logic [WIDTH:0] y_q, y_d;
    logic           ovf_q, ovf_d;
    logic           outValid_q, outValid_d;
    logic [WIDTH:0] aluY, aluAcc;
    logic           aluOvf;
    logic           accept;

    add_accum_alu #(
        .WIDTH   (WIDTH),
        .SATURATE(SATURATE)
    ) u_alu (
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .acc_i     (acc_q),
        .next_y_o  (aluY),
        .next_acc_o(aluAcc),
        .next_ovf_o(aluOvf)
    );

    assign in_ready_o = !outValid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // A stalled result freezes everything; a drain with a new accept replaces it.
    always_comb begin
        acc_d      = acc_q;
        y_d        = y_q;
        ovf_d      = ovf_q;
        outValid_d = outValid_q;
        if (accept) begin
            acc_d      = aluAcc;
            y_d        = aluY;
            ovf_d      = aluOvf;
            outValid_d = 1'b1;
        end else if (out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            y_q        <= '0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            y_q        <= y_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
        end
    end

    assign y_o         = y_q;
    assign ovf_o       = ovf_q;
    assign out_valid_o = outValid_q;

endmodule

// File: doc/add_accum.md
# add_accum

Parametrised, registered successor to the combinational 4-bit adder. Performs ADD, SUB, ACC (running accumulate) or CLR on WIDTH-bit operands with a valid/ready handshake on both sides, one-cycle latency and full throughput. Sits between a stimulus source (switches/UART/bench) and a display or consumer that may apply backpressure.

## Interface
- WIDTH, 4, operand width in bits; result and accumulator are WIDTH+1 bits.
- SATURATE, 0, 0 = accumulator wraps on overflow, 1 = accumulator clamps to all-ones.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept this cycle.
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned; ignored for ACC/CLR).
- out_valid  out  1  result held in y/ovf.
- out_ready  in  1  consumer takes result.
- y  out  WIDTH+1  result.
- ovf  out  1  accumulator overflow flag for this result.

## Operation
- Accept = in_valid & in_ready. Only on accept is op executed, acc updated and y/ovf loaded.
- ADD: y = a + b zero-extended (carry in MSB); ovf = 0; acc unchanged.
- SUB: y = {1'b0,a} - {1'b0,b} mod 2^(WIDTH+1) (two's complement; MSB=1 means a<b); ovf = 0; acc unchanged.
- ACC: s = acc + a computed at WIDTH+2 bits. If s < 2^(WIDTH+1): acc = s, ovf = 0. Else ovf = 1 and acc = s mod 2^(WIDTH+1) (SATURATE=0) or all-ones (SATURATE=1). y = new acc.
- CLR: acc = 0, y = 0, ovf = 0.
- Output stage: out_valid set on accept; cleared on out_valid & out_ready with no accept in the same cycle.
- in_ready = !out_valid | out_ready (combinational, no dependence on in_valid).
- While out_valid & !out_ready: y, ovf, out_valid and acc frozen; in_ready = 0.
- Simultaneous drain and accept: new result replaces old; out_valid stays 1.

## Timing
- Reset values: out_valid 0, y 0, ovf 0, acc 0; hence in_ready 1 in the first cycle after reset.
- Latency: accept at edge N -> y/ovf/out_valid valid after edge N (visible cycle N+1).
- Throughput: one op per cycle while out_ready = 1.
- Reset mid-operation: pending output discarded, acc cleared, any in_valid in the reset cycle is not accepted.
- No combinational path from a/b/op to any output; in_ready depends only on out_valid and out_ready.

## Structure
- Shared package add_accum_pkg: op encodings (OP_ADD, OP_SUB, OP_ACC, OP_CLR) as localparams; reused by bench and future ALU blocks.
- Sub-module add_accum_alu: purely combinational, inputs op/a/b/acc, outputs next_y, next_acc, next_ovf, parametrised by WIDTH and SATURATE. Top holds acc, output register and handshake.

## Test plan
- WIDTH=4: ADD a=15 b=15, out_ready=1 -> next cycle out_valid=1, y=30 (5'b11110), ovf=0.
- SUB a=3 b=5 -> y=5'b11110, ovf=0; SUB a=9 b=4 -> y=5; acc unaffected (subsequent ACC a=0 returns y=0).
- SATURATE=0: CLR, then ACC 15,15,15 back-to-back -> y=15,30,13 on consecutive cycles, ovf=0,0,1. SATURATE=1 same -> y=15,30,31, ovf=0,0,1.
- Backpressure: result pending, out_ready=0 for 3 cycles with in_valid=1 ACC a=1 -> in_ready=0, y/acc frozen; out_ready=1 -> accept occurs that cycle, acc increments exactly once.
- Reset mid-stream: ACC to acc=20, assert rst one cycle with in_valid=1 -> out_valid=0, y=0, ovf=0; next ACC a=2 yields y=2.
- Random 25-op run with random out_ready vs reference model -> every accepted op produces exactly one output, in order, matching model.
